wave_generator: RTL and testbench

- Parametrised successor to the fixed 0..2^N-1 triangle counter.
- Generates triangle, rising sawtooth, falling sawtooth or square waves.
- Bounds (lo/hi) and step size are programmable at run time; advances only when ena is high.
- Feeds DAC/PWM and test-stimulus paths; the wrap output marks period starts for downstream sync.

---
 rtl/wave_generator.sv | 152 +++++++++++++++
 tb/tb_wave_generator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wave_generator.sv
// Programmable waveform source: triangle, rising/falling sawtooth or square
// between run-time bounds lo..hi, advancing only on enabled cycles.
// Latency: out/dir/wrap are registered, so input changes show one enabled edge later.
// Backpressure: none; ena=0 freezes all state and holds wrap low.
//
// Ports:
//   clk, rst          clock (rising edge) and asynchronous active-high reset
//   ena               advance enable
//   mode              0=TRIANGLE 1=SAW_UP 2=SAW_DOWN 3=SQUARE
//   step              increment (tri/saw) or half-period length (square); 0 acts as 1
//   lo, hi            inclusive unsigned bounds
//   out               waveform sample
//   dir               triangle direction (0=up, 1=down), 0 in other modes
//   wrap              one-cycle period-start marker, aligned with out
module wave_generator #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [1:0]   mode,
    input  logic [N-1:0] step,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    output logic [N-1:0] out,
    output logic         dir,
    output logic         wrap
);

    typedef enum logic [1:0] {
        MODE_TRI       = 2'd0,
        MODE_SAW_UP    = 2'd1,
        MODE_SAW_DOWN  = 2'd2,
        MODE_SQUARE    = 2'd3
    } mode_e;

    localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] out_q, out_d;
    logic         dir_q, dir_d;
    logic         wrap_q, wrap_d;
    logic [N-1:0] cnt_q, cnt_d;

    mode_e        mode_sel;
    logic [N-1:0] s_eff;
    logic [N-1:0] room_up;    // hi - out, valid once out is known in range
    logic [N-1:0] room_down;  // out - lo, valid once out is known in range

    assign mode_sel  = mode_e'(mode);
    assign s_eff     = (step == '0) ? ONE_N : step;
    assign room_up   = hi - out_q;
    assign room_down = out_q - lo;

    // Every add/subtract below is guarded by a headroom comparison, so the
    // result always lands inside lo..hi and never wraps modulo 2^N.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;

        if (ena) begin
            if (lo >= hi) begin
                out_d = lo;
                dir_d = 1'b0;
                cnt_d = '0;
            end else if ((out_q < lo) || (out_q > hi)) begin
                // Falling saw restarts from the top so it begins a full ramp.
                out_d = (mode_sel == MODE_SAW_DOWN) ? hi : lo;
                dir_d = 1'b0;
                cnt_d = '0;
            end else begin
                // Half-period counter only lives in square mode; clearing it
                // elsewhere makes a switch into square start a clean half-period.
                cnt_d = '0;
                dir_d = 1'b0;
                unique case (mode_sel)
                    MODE_TRI: begin
                        if (!dir_q) begin
                            if (room_up <= s_eff) begin
                                out_d = hi;
                                dir_d = 1'b1;
                            end else begin
                                out_d = out_q + s_eff;
                            end
                        end else begin
                            if (room_down <= s_eff) begin
                                out_d  = lo;
                                wrap_d = 1'b1;
                            end else begin
                                out_d = out_q - s_eff;
                                dir_d = 1'b1;
                            end
                        end
                    end
                    MODE_SAW_UP: begin
                        if (out_q == hi) begin
                            out_d  = lo;
                            wrap_d = 1'b1;
                        end else if (room_up <= s_eff) begin
                            out_d = hi;
                        end else begin
                            out_d = out_q + s_eff;
                        end
                    end
                    MODE_SAW_DOWN: begin
                        if (out_q == lo) begin
                            out_d  = hi;
                            wrap_d = 1'b1;
                        end else if (room_down <= s_eff) begin
                            out_d = lo;
                        end else begin
                            out_d = out_q - s_eff;
                        end
                    end
                    MODE_SQUARE: begin
                        if ((out_q != lo) && (out_q != hi)) begin
                            out_d = lo;
                        end else if (cnt_q == (s_eff - ONE_N)) begin
                            out_d  = (out_q == lo) ? hi : lo;
                            wrap_d = (out_q == hi);
                        end else begin
                            cnt_d = cnt_q + ONE_N;
                        end
                    end
                    default: begin
                        out_d = out_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= '0;
            dir_q  <= 1'b0;
            wrap_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            wrap_q <= wrap_d;
            cnt_q  <= cnt_d;
        end
    end

    assign out  = out_q;
    assign dir  = dir_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_wave_generator.sv
// Directed bench for wave_generator with hand-computed expected sequences.
// Latency: samples 1 time unit after each rising edge.
// Backpressure: n/a; drives ena directly.
module tb_wave_generator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] step = 8'd0;
    logic [7:0] lo = 8'd0;
    logic [7:0] hi = 8'd0;
    logic [7:0] out;
    logic       dir;
    logic       wrap;

    int n_chk = 0;
    int n_err = 0;

    wave_generator #(.N(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .mode (mode),
        .step (step),
        .lo   (lo),
        .hi   (hi),
        .out  (out),
        .dir  (dir),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_seq(input string tag, input int o, input int d, input int w);
        check({tag, ".out"}, 32'(out), 32'(o));
        check({tag, ".dir"}, 32'(dir), 32'(d));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        int exp_o, exp_d, exp_w, prev;
        int t_o[8], t_d[8], t_w[8];
        int s_o[10], s_w[10];

        // Reset values while rst held.
        #12;
        check_seq("reset", 0, 0, 0);

        // Full-range triangle, step 1.
        mode = 2'd0; lo = 8'd0; hi = 8'd255; step = 8'd1; ena = 1'b1;
        do_reset();
        check_seq("tri_full.rst", 0, 0, 0);
        for (int i = 1; i <= 520; i++) begin
            tick();
            if (i <= 255)      exp_o = i;
            else if (i <= 510) exp_o = 510 - i;
            else               exp_o = i - 510;
            exp_d = (i >= 255 && i < 510) ? 1 : 0;
            exp_w = (i == 510) ? 1 : 0;
            check_seq("tri_full", exp_o, exp_d, exp_w);
        end

        // Triangle lo=10 hi=20 step=4 from reset (first edge is out-of-range).
        lo = 8'd10; hi = 8'd20; step = 8'd4;
        do_reset();
        t_o = '{10, 14, 18, 20, 16, 12, 10, 14};
        t_d = '{0, 0, 0, 1, 1, 1, 0, 0};
        t_w = '{0, 0, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 8; i++) begin
            tick();
            check_seq("tri_10_20", t_o[i], t_d[i], t_w[i]);
        end

        // step=0 behaves like step=1.
        step = 8'd0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_seq("tri_step0", 10 + i, 0, 0);
        end

        // Rising sawtooth 0..7 step 3.
        mode = 2'd1; lo = 8'd0; hi = 8'd7; step = 8'd3;
        do_reset();
        check_seq("saw_up.rst", 0, 0, 0);
        t_o[0:4] = '{3, 6, 7, 0, 3};
        t_w[0:4] = '{0, 0, 0, 1, 0};
        for (int i = 0; i < 5; i++) begin
            tick();
            check_seq("saw_up", t_o[i], 0, t_w[i]);
        end

        // Falling sawtooth same bounds.
        mode = 2'd2;
        do_reset();
        t_o[0:4] = '{7, 4, 1, 0, 7};
        t_w[0:4] = '{1, 0, 0, 0, 1};
        for (int i = 0; i < 5; i++) begin
            tick();
            check_seq("saw_down", t_o[i], 0, t_w[i]);
        end

        // Square lo=2 hi=9 half-period 3.
        mode = 2'd3; lo = 8'd2; hi = 8'd9; step = 8'd3;
        do_reset();
        s_o = '{2, 2, 2, 9, 9, 9, 2, 2, 2, 9};
        s_w = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            tick();
            check_seq("square", s_o[i], 0, s_w[i]);
        end

        // Square with ena alternating: enabled edges continue the same sequence.
        s_o[0:5] = '{9, 9, 2, 2, 2, 9};
        s_w[0:5] = '{0, 0, 1, 0, 0, 0};
        prev = 9;
        for (int k = 0; k < 6; k++) begin
            ena = 1'b0;
            tick();
            check_seq("square_hold", prev, 0, 0);
            ena = 1'b1;
            tick();
            check_seq("square_ena", s_o[k], 0, s_w[k]);
            prev = s_o[k];
        end

        // Freeze mid-ramp on the falling half of a triangle.
        mode = 2'd0; lo = 8'd0; hi = 8'd20; step = 8'd5;
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        check_seq("freeze.pre", 15, 1, 0);
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_seq("freeze", 15, 1, 0);
        end
        ena = 1'b1;
        tick();
        check_seq("freeze.resume", 10, 1, 0);

        // Upper bound pulled below out: back to lo, no wrap.
        hi = 8'd5;
        tick();
        check_seq("bound_shrink", 0, 0, 0);

        // Degenerate bounds lo==hi.
        lo = 8'd5; hi = 8'd5; step = 8'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_seq("lo_eq_hi", 5, 0, 0);
        end
        mode = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_seq("lo_eq_hi_saw", 5, 0, 0);
        end

        // Asynchronous reset between edges.
        mode = 2'd0; lo = 8'd0; hi = 8'd4; step = 8'd4;
        do_reset();
        tick();
        check_seq("arst.pre", 4, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_seq("arst", 0, 0, 0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
